wave_dds_ctrl: RTL and testbench

WAVE_DDS_CTRL -- requirements
Module: wave_dds_ctrl

---
 rtl/wave_dds_ctrl.sv | 137 +++++++++++++
 tb/tb_wave_dds_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/wave_dds_ctrl.sv
// Waveform DDS controller: phase accumulator driving a 4-wave x 4096-entry ROM address,
// with waveform changes deferred to the accumulator wrap so each period completes cleanly.
module wave_dds_ctrl #(
    parameter logic [31:0] FREQ_CTRL  = 32'd42950,
    parameter logic [11:0] PHASE_CTRL = 12'd1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  wave_select,
    output logic [13:0] rom_addr,
    output logic [1:0]  wave_idx,
    output logic        out_valid,
    output logic        switch_pend
);

    typedef enum logic [1:0] {StIdle, StRun, StSwitch} state_e;

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [13:0] rom_addr_q, rom_addr_d;
    logic [1:0]  wave_idx_q, wave_idx_d;
    logic [1:0]  pend_idx_q, pend_idx_d;
    logic        out_valid_q, out_valid_d;
    logic        switch_pend_q, switch_pend_d;

    logic        sel_zero;
    logic        sel_valid;
    logic [1:0]  sel_idx;
    logic        wrap;
    logic [31:0] acc_sum;

    always_comb begin
        sel_zero  = (wave_select == 4'b0000);
        sel_valid = 1'b1;
        sel_idx   = 2'd0;
        case (wave_select)
            4'b0001: sel_idx = 2'd0;
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_valid = 1'b0;
        endcase
    end

    // Wrap is the carry out of the accumulator addition.
    assign {wrap, acc_sum} = {1'b0, acc_q} + {1'b0, FREQ_CTRL};

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        rom_addr_d    = rom_addr_q;
        wave_idx_d    = wave_idx_q;
        pend_idx_d    = pend_idx_q;
        out_valid_d   = out_valid_q;
        switch_pend_d = switch_pend_q;

        case (state_q)
            StIdle: begin
                acc_d         = 32'd0;
                rom_addr_d    = 14'd0;
                out_valid_d   = 1'b0;
                switch_pend_d = 1'b0;
                if (sel_valid) begin
                    wave_idx_d  = sel_idx;
                    rom_addr_d  = {sel_idx, PHASE_CTRL};
                    out_valid_d = 1'b1;
                    state_d     = StRun;
                end
            end
            StRun, StSwitch: begin
                if (sel_zero) begin
                    // Stop wins over a simultaneous wrap; wave_idx is kept.
                    state_d       = StIdle;
                    acc_d         = 32'd0;
                    rom_addr_d    = 14'd0;
                    out_valid_d   = 1'b0;
                    switch_pend_d = 1'b0;
                end else begin
                    acc_d       = acc_sum;
                    out_valid_d = 1'b1;
                    if (state_q == StRun) begin
                        if (sel_valid && (sel_idx != wave_idx_q)) begin
                            pend_idx_d    = sel_idx;
                            switch_pend_d = 1'b1;
                            state_d       = StSwitch;
                        end
                    end else if (wrap) begin
                        wave_idx_d    = pend_idx_q;
                        switch_pend_d = 1'b0;
                        state_d       = StRun;
                        // A differing request on the wrap cycle becomes a fresh pending change.
                        if (sel_valid && (sel_idx != pend_idx_q)) begin
                            pend_idx_d    = sel_idx;
                            switch_pend_d = 1'b1;
                            state_d       = StSwitch;
                        end
                    end else if (sel_valid) begin
                        if (sel_idx == wave_idx_q) begin
                            switch_pend_d = 1'b0;
                            state_d       = StRun;
                        end else begin
                            pend_idx_d = sel_idx;
                        end
                    end
                    rom_addr_d = {wave_idx_d, acc_sum[31:20] + PHASE_CTRL};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= StIdle;
            acc_q         <= 32'd0;
            rom_addr_q    <= 14'd0;
            wave_idx_q    <= 2'd0;
            pend_idx_q    <= 2'd0;
            out_valid_q   <= 1'b0;
            switch_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            rom_addr_q    <= rom_addr_d;
            wave_idx_q    <= wave_idx_d;
            pend_idx_q    <= pend_idx_d;
            out_valid_q   <= out_valid_d;
            switch_pend_q <= switch_pend_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign wave_idx    = wave_idx_q;
    assign out_valid   = out_valid_q;
    assign switch_pend = switch_pend_q;

endmodule

// File: tb/tb_wave_dds_ctrl.sv
// Directed bench for wave_dds_ctrl with a 16-cycle wrap (phase step 256, no phase offset).
module tb_wave_dds_ctrl;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [3:0]  wave_select;
    logic [13:0] rom_addr;
    logic [1:0]  wave_idx;
    logic        out_valid;
    logic        switch_pend;

    wave_dds_ctrl #(
        .FREQ_CTRL  (32'h1000_0000),
        .PHASE_CTRL (12'd0)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .wave_select (wave_select),
        .rom_addr    (rom_addr),
        .wave_idx    (wave_idx),
        .out_valid   (out_valid),
        .switch_pend (switch_pend)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [13:0] addr;
        logic [1:0]  idx;
        logic        v;
        logic        p;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic [3:0] ph = 4'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one code, queue the expected post-edge outputs, then check after the edge.
    task automatic step(input logic [3:0] ws, input logic [1:0] idx, input logic [3:0] p,
                        input logic v, input logic pd, input string tag);
        exp_t e;
        wave_select = ws;
        e.addr = v ? {idx, p, 8'h00} : 14'h0000;
        e.idx  = idx;
        e.v    = v;
        e.p    = pd;
        sb.push_back(e);
        @(posedge sys_clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".addr"}, 32'(rom_addr), 32'(e.addr));
        chk({tag, ".idx"}, 32'(wave_idx), 32'(e.idx));
        chk({tag, ".valid"}, 32'(out_valid), 32'(e.v));
        chk({tag, ".pend"}, 32'(switch_pend), 32'(e.p));
    endtask

    task automatic run(input logic [3:0] ws, input logic [1:0] idx, input logic pd,
                       input string tag);
        ph = ph + 4'd1;
        step(ws, idx, ph, 1'b1, pd, tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".addr"}, 32'(rom_addr), 32'h0);
        chk({tag, ".idx"}, 32'(wave_idx), 32'h0);
        chk({tag, ".valid"}, 32'(out_valid), 32'h0);
        chk({tag, ".pend"}, 32'(switch_pend), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sys_rst_n   = 1'b0;
        wave_select = 4'b0000;
        repeat (2) @(posedge sys_clk);
        #1;
        chk_zero("reset");
        sys_rst_n = 1'b1;

        step(4'b0000, 2'd0, 4'd0, 1'b0, 1'b0, "idle_zero");
        step(4'b0011, 2'd0, 4'd0, 1'b0, 1'b0, "idle_0011");
        step(4'b1111, 2'd0, 4'd0, 1'b0, 1'b0, "idle_1111");

        // Sine start and one full period, ending on the wrap back to phase 0.
        ph = 4'd0;
        step(4'b0001, 2'd0, 4'd0, 1'b1, 1'b0, "sine_start");
        for (int i = 0; i < 16; i++) run(4'b0001, 2'd0, 1'b0, "sine_run");

        // Request triangle at phase 1024; change lands on the wrap.
        for (int i = 0; i < 4; i++) run(4'b0001, 2'd0, 1'b0, "sine_pre");
        run(4'b0100, 2'd0, 1'b1, "sw_req");
        run(4'b1111, 2'd0, 1'b1, "sw_1111");
        run(4'b0011, 2'd0, 1'b1, "sw_0011");
        while (ph != 4'hF) run(4'b0100, 2'd0, 1'b1, "sw_wait");
        run(4'b0100, 2'd2, 1'b0, "sw_wrap");

        // Pending square cancelled by returning to the current code.
        run(4'b0010, 2'd2, 1'b1, "cx_req");
        run(4'b0100, 2'd2, 1'b0, "cx_cancel");
        while (ph != 4'hF) run(4'b0100, 2'd2, 1'b0, "cx_run");
        run(4'b0100, 2'd2, 1'b0, "cx_wrap");

        // New code on the wrap cycle: old pending applied, new one latched.
        run(4'b0010, 2'd2, 1'b1, "dbl_req");
        while (ph != 4'hF) run(4'b0010, 2'd2, 1'b1, "dbl_wait");
        run(4'b1000, 2'd1, 1'b1, "dbl_wrap");
        while (ph != 4'hF) run(4'b1000, 2'd1, 1'b1, "dbl_wait2");
        run(4'b1000, 2'd3, 1'b0, "dbl_wrap2");

        // Stop from sawtooth keeps wave_idx.
        for (int i = 0; i < 3; i++) run(4'b1000, 2'd3, 1'b0, "saw_run");
        step(4'b0000, 2'd3, 4'd0, 1'b0, 1'b0, "stop");
        step(4'b0000, 2'd3, 4'd0, 1'b0, 1'b0, "stop_hold");
        step(4'b1111, 2'd3, 4'd0, 1'b0, 1'b0, "stop_1111");

        // Stop wins over a wrap while a switch is pending.
        ph = 4'd0;
        step(4'b0010, 2'd1, 4'd0, 1'b1, 1'b0, "pr_start");
        run(4'b0001, 2'd1, 1'b1, "pr_req");
        while (ph != 4'hF) run(4'b0001, 2'd1, 1'b1, "pr_wait");
        step(4'b0000, 2'd1, 4'd0, 1'b0, 1'b0, "pr_stop_wrap");

        // Reset during SWITCH discards the pending change.
        ph = 4'd0;
        step(4'b0001, 2'd0, 4'd0, 1'b1, 1'b0, "rst_start");
        run(4'b1000, 2'd0, 1'b1, "rst_req");
        run(4'b1000, 2'd0, 1'b1, "rst_wait");
        wave_select = 4'b0000;
        sys_rst_n   = 1'b0;
        #1;
        chk_zero("rst_async");
        #2;
        sys_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(4'b0000, 2'd0, 4'd0, 1'b0, 1'b0, "rst_idle");
        ph = 4'd0;
        step(4'b0100, 2'd2, 4'd0, 1'b1, 1'b0, "post_start");
        run(4'b0100, 2'd2, 1'b0, "post_run");
        run(4'b0100, 2'd2, 1'b0, "post_run");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
